scmp_bus_responder: RTL

Memory-side responder for the SC/MP processor bus. Decodes each bus cycle from the core's address strobe, read strobe and write strobe. Rebuilds the 16-bit address from the 12 address lines plus the high nibble multiplexed on the data bus. Serves reads and writes against a synchronous memory port with programmable read latency. Also exports the per-cycle status flags (H, D, I, R) to the rest of the system.

---
 rtl/scmp_bus_responder.sv | 98 +++++++++
 1 files changed

// File: rtl/scmp_bus_responder.sv
// scmp_bus_responder: SC/MP bus cycle decoder serving reads/writes against a
// synchronous memory port with programmable read latency.
module scmp_bus_responder #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ADS_n,
  input  logic        RD_n,
  input  logic        WR_n,
  input  logic [11:0] addr,
  input  logic [7:0]  bus_d_i,
  output logic [7:0]  bus_d_o,
  output logic        bus_d_oe,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  output logic [3:0]  cyc_flags,
  output logic        ifetch,
  output logic        halt_pulse,
  output logic        err,
  input  logic        err_clr
);
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_HOLD, WR_WAIT, WR_COMMIT} state_t;
  state_t     st;
  logic [1:0] cnt;
  logic [7:0] rdata_q;
  logic       rd_q;
  logic       err_set;
  // a write strobe is illegal in a read cycle or outside any cycle
  assign err_set = (!ADS_n && (!RD_n || !WR_n)) || (!RD_n && st != RD_HOLD) ||
                   (!WR_n && (cyc_flags[0] || st == IDLE));
  assign bus_d_oe = !RD_n;
  assign bus_d_o  = (st == RD_HOLD && !RD_n) ? rdata_q : 8'hFF;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      cnt        <= 2'd0;
      rdata_q    <= 8'd0;
      rd_q       <= 1'b1;
      mem_addr   <= 16'd0;
      mem_wdata  <= 8'd0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      cyc_flags  <= 4'd0;
      ifetch     <= 1'b0;
      halt_pulse <= 1'b0;
      err        <= 1'b0;
    end else begin
      rd_q       <= RD_n;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      halt_pulse <= 1'b0;
      err        <= err_set || (err && !err_clr);
      if (!ADS_n) begin
        mem_addr   <= {bus_d_i[3:0], addr};
        cyc_flags  <= bus_d_i[7:4];
        ifetch     <= bus_d_i[5];
        halt_pulse <= bus_d_i[7];
        mem_re     <= bus_d_i[4];
        st         <= bus_d_i[4] ? RD_ISSUE : WR_WAIT;
      end else begin
        case (st)
          RD_ISSUE: begin
            cnt <= 2'(MEM_LAT - 1);
            st  <= RD_WAIT;
          end
          RD_WAIT: begin
            if (cnt == 2'd0) begin
              rdata_q <= mem_rdata;
              st      <= RD_HOLD;
            end else cnt <= cnt - 2'd1;
          end
          RD_HOLD: begin
            if (!rd_q && RD_n) begin
              st     <= IDLE;
              ifetch <= 1'b0;
            end
          end
          WR_WAIT: begin
            if (!WR_n) begin
              mem_wdata <= bus_d_i;
              mem_we    <= 1'b1;
              st        <= WR_COMMIT;
            end
          end
          WR_COMMIT: begin
            st     <= IDLE;
            ifetch <= 1'b0;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule
